trace_pkt_serializer: RTL and testbench

//  Downstream stage of the continuous monitoring system. It accepts one wide trace packet per AXI-Stream

---
 rtl/continuous_monitoring_system_pkg.sv | 14 +
 rtl/trace_pkt_serializer.sv | 134 +++++++++++++
 tb/tb_trace_pkt_serializer.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/continuous_monitoring_system_pkg.sv
// rtl/continuous_monitoring_system_pkg.sv - shared widths, constants and state types for the monitoring pipeline
package continuous_monitoring_system_pkg;

    localparam int          AXI_DATA_WIDTH          = 256;
    localparam int          SERIALIZER_OUT_WIDTH    = 64;
    localparam logic [15:0] SERIALIZER_HEADER_MAGIC = 16'hC0DE;

    typedef enum logic [1:0] {
        SER_IDLE,
        SER_HEADER,
        SER_SEND
    } serializer_state_t;

endpackage

// File: rtl/trace_pkt_serializer.sv
// rtl/trace_pkt_serializer.sv - splits one wide trace packet into OUT_WIDTH-bit stream beats, LS word first
// Optional TRACE_SERIALIZER_SEQ_HEADER_EN prefixes each packet with a {magic, beats, seq} header beat.
module trace_pkt_serializer
    import continuous_monitoring_system_pkg::*;
#(
    parameter int IN_WIDTH  = AXI_DATA_WIDTH,
    parameter int OUT_WIDTH = SERIALIZER_OUT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    input  logic [IN_WIDTH-1:0]  s_axis_tdata,
    input  logic                 s_axis_tlast,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic [OUT_WIDTH-1:0] m_axis_tdata,
    output logic                 m_axis_tlast,
    output logic [31:0]          pkt_count,
    output logic                 busy
);

    localparam int BEATS = (IN_WIDTH + OUT_WIDTH - 1) / OUT_WIDTH;
    localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PAD_W = BEATS * OUT_WIDTH;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

`ifdef TRACE_SERIALIZER_SEQ_HEADER_EN
    localparam serializer_state_t PKT_START = SER_HEADER;
`else
    localparam serializer_state_t PKT_START = SER_SEND;
`endif

    serializer_state_t state, state_nxt;

    logic [PAD_W-1:0] held_data;
    logic             held_tlast;
    logic [IDX_W-1:0] beat_idx;
    logic             last_beat;
    logic             accept;
    logic             send_hs;

`ifdef TRACE_SERIALIZER_SEQ_HEADER_EN
    logic [31:0] seq_cnt;
    logic [31:0] held_seq;
    logic [63:0] header_word;

    assign header_word = {SERIALIZER_HEADER_MAGIC, 16'(BEATS), held_seq};
`endif

    assign last_beat = (beat_idx == LAST_IDX);
    assign accept    = s_axis_tvalid & s_axis_tready;
    assign send_hs   = (state == SER_SEND) & m_axis_tready;
    assign busy      = (state != SER_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SER_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Outputs decode from registered state only, so nothing on s_axis reaches m_axis combinationally.
    always_comb begin
        state_nxt     = state;
        s_axis_tready = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tlast  = 1'b0;
        case (state)
            SER_IDLE: begin
                s_axis_tready = 1'b1;
                if (s_axis_tvalid) begin
                    state_nxt = PKT_START;
                end
            end
`ifdef TRACE_SERIALIZER_SEQ_HEADER_EN
            SER_HEADER: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = OUT_WIDTH'(header_word);
                if (m_axis_tready) begin
                    state_nxt = SER_SEND;
                end
            end
`endif
            SER_SEND: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = held_data[int'(beat_idx) * OUT_WIDTH +: OUT_WIDTH];
                m_axis_tlast  = held_tlast & last_beat;
                if (m_axis_tready && last_beat) begin
                    s_axis_tready = 1'b1;
                    state_nxt     = s_axis_tvalid ? PKT_START : SER_IDLE;
                end
            end
            default: begin
                state_nxt = SER_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_data  <= '0;
            held_tlast <= 1'b0;
            beat_idx   <= '0;
            pkt_count  <= '0;
        end else begin
            if (accept) begin
                held_data  <= PAD_W'(s_axis_tdata);
                held_tlast <= s_axis_tlast;
                beat_idx   <= '0;
            end else if (send_hs) begin
                beat_idx <= last_beat ? '0 : beat_idx + 1'b1;
            end
            if (send_hs && last_beat) begin
                pkt_count <= pkt_count + 32'd1;
            end
        end
    end

`ifdef TRACE_SERIALIZER_SEQ_HEADER_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_cnt  <= '0;
            held_seq <= '0;
        end else if (accept) begin
            held_seq <= seq_cnt;
            seq_cnt  <= seq_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_trace_pkt_serializer.sv
// tb/tb_trace_pkt_serializer.sv - scoreboard bench for trace_pkt_serializer (4-beat and 1-beat instances)
module tb_trace_pkt_serializer;

`ifdef TRACE_SERIALIZER_SEQ_HEADER_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif

    typedef struct packed {
        logic [63:0] data;
        logic        last;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic         s0_tvalid, s0_tready, s0_tlast;
    logic [255:0] s0_tdata;
    logic         m0_tvalid, m0_tready, m0_tlast;
    logic [63:0]  m0_tdata;
    logic [31:0]  pc0;
    logic         busy0;

    logic         s1_tvalid, s1_tready, s1_tlast;
    logic [63:0]  s1_tdata;
    logic         m1_tvalid, m1_tready, m1_tlast;
    logic [63:0]  m1_tdata;
    logic [31:0]  pc1;
    logic         busy1;

    trace_pkt_serializer #(.IN_WIDTH(256), .OUT_WIDTH(64)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tvalid(s0_tvalid), .s_axis_tready(s0_tready), .s_axis_tdata(s0_tdata), .s_axis_tlast(s0_tlast),
        .m_axis_tvalid(m0_tvalid), .m_axis_tready(m0_tready), .m_axis_tdata(m0_tdata), .m_axis_tlast(m0_tlast),
        .pkt_count(pc0), .busy(busy0)
    );

    trace_pkt_serializer #(.IN_WIDTH(64), .OUT_WIDTH(64)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tvalid(s1_tvalid), .s_axis_tready(s1_tready), .s_axis_tdata(s1_tdata), .s_axis_tlast(s1_tlast),
        .m_axis_tvalid(m1_tvalid), .m_axis_tready(m1_tready), .m_axis_tdata(m1_tdata), .m_axis_tlast(m1_tlast),
        .pkt_count(pc1), .busy(busy1)
    );

    int n_pass = 0;
    int n_total = 0;
    int seq0 = 0;
    int seq1 = 0;
    beat_t sb0[$];
    beat_t sb1[$];
    int obs0[$];
    int obs1[$];
    int nobs0 = 0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    beat_t e0, e1;
    logic        stall0;
    logic [63:0] pd0;
    logic        pl0;

    always @(negedge clk) begin
        if (!rst_n) begin
            stall0 <= 1'b0;
        end else begin
            if (stall0) begin
                check("stall_valid", 256'(m0_tvalid), 256'(1'b1));
                check("stall_data", 256'(m0_tdata), 256'(pd0));
                check("stall_last", 256'(m0_tlast), 256'(pl0));
            end
            if (m0_tvalid && m0_tready) begin
                check("beat0_expected", 256'(sb0.size() != 0), 256'(1'b1));
                if (sb0.size() != 0) begin
                    e0 = sb0.pop_front();
                    check("beat0_data", 256'(m0_tdata), 256'(e0.data));
                    check("beat0_last", 256'(m0_tlast), 256'(e0.last));
                end
                obs0.push_back(cyc);
                nobs0 <= nobs0 + 1;
            end
            stall0 <= m0_tvalid & ~m0_tready;
            pd0    <= m0_tdata;
            pl0    <= m0_tlast;
        end
    end

    always @(negedge clk) begin
        if (rst_n && m1_tvalid && m1_tready) begin
            check("beat1_expected", 256'(sb1.size() != 0), 256'(1'b1));
            if (sb1.size() != 0) begin
                e1 = sb1.pop_front();
                check("beat1_data", 256'(m1_tdata), 256'(e1.data));
                check("beat1_last", 256'(m1_tlast), 256'(e1.last));
            end
            obs1.push_back(cyc);
        end
    end

    task automatic push_exp0(input logic [255:0] d, input logic l);
`ifdef TRACE_SERIALIZER_SEQ_HEADER_EN
        sb0.push_back('{data: {16'hC0DE, 16'd4, 32'(seq0)}, last: 1'b0});
        seq0++;
`endif
        for (int i = 0; i < 4; i++) begin
            sb0.push_back('{data: d[i*64 +: 64], last: l && (i == 3)});
        end
    endtask

    task automatic send0(input logic [255:0] d, input logic l, output int acc, output int waits);
        s0_tdata = d; s0_tlast = l; s0_tvalid = 1'b1;
        waits = 0; acc = -1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk); #1;
            if (s0_tready) begin
                acc = cyc;
                push_exp0(d, l);
                break;
            end
            waits++;
        end
        if (acc < 0) check("send0_accept", 256'(s0_tready), 256'(1'b1));
        @(posedge clk); #1;
        s0_tvalid = 1'b0;
    endtask

    task automatic send1(input logic [63:0] d, input logic l, output int acc, output int waits);
        s1_tdata = d; s1_tlast = l; s1_tvalid = 1'b1;
        waits = 0; acc = -1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk); #1;
            if (s1_tready) begin
                acc = cyc;
`ifdef TRACE_SERIALIZER_SEQ_HEADER_EN
                sb1.push_back('{data: {16'hC0DE, 16'd1, 32'(seq1)}, last: 1'b0});
                seq1++;
`endif
                sb1.push_back('{data: d, last: l});
                break;
            end
            waits++;
        end
        if (acc < 0) check("send1_accept", 256'(s1_tready), 256'(1'b1));
        @(posedge clk); #1;
        s1_tvalid = 1'b0;
    endtask

    task automatic drain0();
        for (int k = 0; k < 200 && sb0.size() != 0; k++) begin
            @(negedge clk); #1;
        end
        check("drain0", 256'(sb0.size()), 256'(0));
        @(posedge clk); #1;
    endtask

    task automatic drain1();
        for (int k = 0; k < 200 && sb1.size() != 0; k++) begin
            @(negedge clk); #1;
        end
        check("drain1", 256'(sb1.size()), 256'(0));
        @(posedge clk); #1;
    endtask

    task automatic check_contig0(input string tag, input int first_acc, input int n);
        check(tag, 256'(obs0.size()), 256'(n));
        for (int i = 0; i < n && i < obs0.size(); i++) begin
            check(tag, 256'(obs0[i]), 256'(first_acc + 1 + i));
        end
    endtask

    int acc, acc_first, w;
    logic [255:0] d;
    logic [3:0] pat;

    initial begin
        s0_tvalid = 1'b0; s0_tdata = '0; s0_tlast = 1'b0; m0_tready = 1'b1;
        s1_tvalid = 1'b0; s1_tdata = '0; s1_tlast = 1'b0; m1_tready = 1'b1;
        pat = 4'b1001;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_s_tready", 256'(s0_tready), 256'(1'b1));
        check("rst_m_tvalid", 256'(m0_tvalid), 256'(1'b0));
        check("rst_m_tdata", 256'(m0_tdata), 256'(0));
        check("rst_m_tlast", 256'(m0_tlast), 256'(1'b0));
        check("rst_pkt_count", 256'(pc0), 256'(0));
        check("rst_busy", 256'(busy0), 256'(1'b0));
        check("rst1_m_tvalid", 256'(m1_tvalid), 256'(1'b0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // single packet, full-rate sink
        d = {64'hD3D3_0000_0000_0003, 64'hD2D2_0000_0000_0002, 64'hD1D1_0000_0000_0001, 64'hD0D0_0000_0000_0000};
        obs0.delete();
        send0(d, 1'b0, acc, w);
        check("t1_busy", 256'(busy0), 256'(1'b1));
        drain0();
        check_contig0("t1_latency", acc, 4 + HDR);
        check("t1_pkt_count", 256'(pc0), 256'(1));
        check("t1_idle_valid", 256'(m0_tvalid), 256'(1'b0));

        // back-to-back packets, second ends the trace
        obs0.delete();
        send0({64'hA3, 64'hA2, 64'hA1, 64'hA0}, 1'b0, acc_first, w);
        send0({64'hB3, 64'hB2, 64'hB1, 64'hB0}, 1'b1, acc, w);
        check("t2_tready_low_cycles", 256'(w), 256'(3 + HDR));
        drain0();
        check_contig0("t2_no_bubble", acc_first, 2 * (4 + HDR));
        check("t2_pkt_count", 256'(pc0), 256'(3));

        // sink stalls in a 1,0,0,1 pattern
        send0({64'hC3C3, 64'hC2C2, 64'hC1C1, 64'hC0C0}, 1'b1, acc, w);
        for (int i = 0; i < 24; i++) begin
            m0_tready = pat[i % 4];
            @(posedge clk); #1;
        end
        m0_tready = 1'b1;
        drain0();
        check("t3_pkt_count", 256'(pc0), 256'(4));

        // reset after the second data beat handshakes
        acc_first = nobs0;
        send0({64'hE3, 64'hE2, 64'hE1, 64'hE0}, 1'b0, acc, w);
        for (int k = 0; k < 100 && nobs0 < acc_first + 2 + HDR; k++) begin
            @(negedge clk); #1;
        end
        check("t4_reached_beat1", 256'(nobs0 >= acc_first + 2 + HDR), 256'(1'b1));
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("t4_m_tvalid", 256'(m0_tvalid), 256'(1'b0));
        check("t4_m_tdata", 256'(m0_tdata), 256'(0));
        check("t4_m_tlast", 256'(m0_tlast), 256'(1'b0));
        check("t4_pkt_count", 256'(pc0), 256'(0));
        check("t4_busy", 256'(busy0), 256'(1'b0));
        check("t4_s_tready", 256'(s0_tready), 256'(1'b1));
        sb0.delete();
        seq0 = 0;
        seq1 = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        obs0.delete();
        send0({64'hF3, 64'hF2, 64'hF1, 64'hF0}, 1'b1, acc, w);
        drain0();
        check_contig0("t4_restart", acc, 4 + HDR);
        check("t4_pkt_count_after", 256'(pc0), 256'(1));

        // one-beat instance, three packets back to back
        obs1.delete();
        send1(64'h11, 1'b0, acc_first, w);
        send1(64'h22, 1'b0, acc, w);
        check("t6_wait2", 256'(w), 256'(HDR));
        send1(64'h33, 1'b1, acc, w);
        check("t6_wait3", 256'(w), 256'(HDR));
        drain1();
        check("t6_nbeats", 256'(obs1.size()), 256'(3 * (1 + HDR)));
        for (int i = 0; i < obs1.size(); i++) begin
            check("t6_latency", 256'(obs1[i]), 256'(acc_first + 1 + i));
        end
        check("t6_pkt_count", 256'(pc1), 256'(3));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
